// File: rtl/operand_load_controller.sv
// operand_load_controller
//   Captures two WIDTH-bit operands from the switch bank into reg_a and reg_b.
//   Each capture needs a debounced, one-shot press of load_btn. The sequence
//   is A, then B, then wrap back to A (which clears B), and so on.
//   reg_a feeds HEX3..HEX0 and reg_b feeds HEX7..HEX4.
//
// Ports
//   clk         in   1      system clock, rising edge
//   reset       in   1      synchronous, active-high reset
//   sw          in   WIDTH  operand value, sampled only on an accept edge
//   load_btn    in   1      load request, active-high, already synchronous to clk
//   reg_a       out  WIDTH  operand A register
//   reg_b       out  WIDTH  operand B register
//   load_a      out  1      one-cycle pulse after reg_a is written
//   load_b      out  1      one-cycle pulse after reg_b is written
//   both_valid  out  1      high while A and B both hold captured operands
//   state       out  2      0=WAIT_A, 1=WAIT_B, 2=FULL
//
// Parameters
//   WIDTH            operand width in bits (a multiple of 4 for the hex display)
//   DEBOUNCE_CYCLES  consecutive high samples needed to accept a press (>=1)

module operand_load_controller #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             load_btn,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic             load_a,
  output logic             load_b,
  output logic             both_valid,
  output logic [1:0]       state
);

  // The counter must be able to hold DEBOUNCE_CYCLES itself because it saturates there.
  localparam int unsigned   CNT_W   = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t           state_q,      state_d;
  logic [WIDTH-1:0] reg_a_q,      reg_a_d;
  logic [WIDTH-1:0] reg_b_q,      reg_b_d;
  logic             load_a_q,     load_a_d;
  logic             load_b_q,     load_b_d;
  logic             both_valid_q, both_valid_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             armed_q,      armed_d;
  logic             accept_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_A;
      reg_a_q      <= '0;
      reg_b_q      <= '0;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      both_valid_q <= 1'b0;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_a_q      <= reg_a_d;
      reg_b_q      <= reg_b_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      both_valid_q <= both_valid_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
    end
  end

  // Debounce, accept detection, next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    reg_a_d      = reg_a_q;
    reg_b_d      = reg_b_q;
    load_a_d     = 1'b0;
    load_b_d     = 1'b0;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    both_valid_d = 1'b0;

    // Accept fires exactly once, on the DEBOUNCE_CYCLES-th consecutive high
    // sample, and only if the button was seen low since the last accept or
    // reset. armed stays low after reset, so a press held through reset is ignored.
    accept_c = load_btn && armed_q && (cnt_q == CNT_ACC);

    if (!load_btn) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (accept_c) begin
        armed_d = 1'b0;
      end
    end

    case (state_q)
      WAIT_A: begin
        if (accept_c) begin
          state_d  = WAIT_B;
          reg_a_d  = sw;
          load_a_d = 1'b1;
        end
      end
      WAIT_B: begin
        if (accept_c) begin
          state_d  = FULL;
          reg_b_d  = sw;
          load_b_d = 1'b1;
        end
      end
      FULL: begin
        // Wrap: a new A invalidates the old B.
        if (accept_c) begin
          state_d  = WAIT_B;
          reg_a_d  = sw;
          reg_b_d  = '0;
          load_a_d = 1'b1;
        end
      end
      default: begin
        // Unused encoding 3: recover to WAIT_A.
        state_d = WAIT_A;
      end
    endcase

    both_valid_d = (state_d == FULL);
  end

  assign reg_a      = reg_a_q;
  assign reg_b      = reg_b_q;
  assign load_a     = load_a_q;
  assign load_b     = load_b_q;
  assign both_valid = both_valid_q;
  assign state      = state_q;

endmodule
